// File: rtl/decoder3to8_pipe_pkg.sv
// ============================================================================
// decoder_pkg : shared defaults, width helper and buffer occupancy encoding
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_pkg;

  localparam int N_IN_DEF = 3;

  function automatic int n_out(input int n);
    return 1 << n;
  endfunction

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

`default_nettype wire

// File: rtl/decoder3to8_pipe_if.sv
// ============================================================================
// decoder3to8_pipe_if : producer/consumer handshake bundle for the decoder
// Rev 1.0 - initial release (parity ports under DECODER3TO8_PIPE_PARITY_EN)
// ============================================================================
`default_nettype none

interface decoder3to8_pipe_if
  import decoder_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [N_IN-1:0]          in_code;
  logic                     in_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [n_out(N_IN)-1:0]   out_onehot;
  logic [N_IN:0]            count;

`ifdef DECODER3TO8_PIPE_PARITY_EN
  logic                     in_parity;
  logic                     out_err;

  modport master (
    output in_valid, in_code, in_en, in_parity, out_ready,
    input  in_ready, out_valid, out_onehot, out_err, count
  );
  modport slave (
    input  in_valid, in_code, in_en, in_parity, out_ready,
    output in_ready, out_valid, out_onehot, out_err, count
  );
`else
  modport master (
    output in_valid, in_code, in_en, out_ready,
    input  in_ready, out_valid, out_onehot, count
  );
  modport slave (
    input  in_valid, in_code, in_en, out_ready,
    output in_ready, out_valid, out_onehot, count
  );
`endif

endinterface

`default_nettype wire

// File: rtl/decoder3to8_pipe_skid_buf2.sv
// ============================================================================
// skid_buf2 : 2-entry valid/ready buffer with registered ready and valid
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_buf2
  import decoder_pkg::*;
#(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         i_valid,
  output logic              o_ready,
  input  wire logic [W-1:0] i_data,
  output logic              o_valid,
  input  wire logic         i_ready,
  output logic [W-1:0]      o_data
);

  occ_e           r_state;
  logic [W-1:0]   r_head;
  logic [W-1:0]   r_tail;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           w_push;
  logic           w_pop;

  assign w_push  = i_valid && r_in_ready;
  assign w_pop   = r_out_valid && i_ready;
  assign o_ready = r_in_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_head;

  // Head is cleared when the buffer drains so the output word reads zero while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_head      <= '0;
      r_tail      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          r_in_ready <= 1'b1;
          if (w_push) begin
            r_head      <= i_data;
            r_out_valid <= 1'b1;
            r_state     <= ONE;
          end
        end
        ONE: begin
          r_in_ready <= 1'b1;
          if (w_push && w_pop) begin
            r_head <= i_data;
          end else if (w_push) begin
            r_tail     <= i_data;
            r_in_ready <= 1'b0;
            r_state    <= FULL;
          end else if (w_pop) begin
            r_head      <= '0;
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_head     <= r_tail;
            r_tail     <= '0;
            r_in_ready <= 1'b1;
            r_state    <= ONE;
          end
        end
        default: begin
          r_head      <= '0;
          r_tail      <= '0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= EMPTY;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/decoder3to8_pipe.sv
// ============================================================================
// decoder3to8_pipe : registered binary-to-one-hot decoder behind a 2-entry skid
// buffer. Optional parity check: DECODER3TO8_PIPE_PARITY_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder3to8_pipe
  import decoder_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int DEPTH = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  decoder3to8_pipe_if.slave bus
);

  localparam int c_N_OUT = n_out(N_IN);
`ifdef DECODER3TO8_PIPE_PARITY_EN
  localparam int c_PAY_W = c_N_OUT + 1;
`else
  localparam int c_PAY_W = c_N_OUT;
`endif

  if (DEPTH != 2) begin : g_depth_chk
    $error("decoder3to8_pipe: only DEPTH=2 is supported");
  end

  logic [c_N_OUT-1:0] w_word;
  logic [c_PAY_W-1:0] w_pay;
  logic [c_PAY_W-1:0] w_head;
  logic               w_out_valid;
  logic               w_in_ready;
  logic [N_IN:0]      r_count;

  assign w_word = bus.in_en ? (c_N_OUT'(1) << bus.in_code) : '0;

`ifdef DECODER3TO8_PIPE_PARITY_EN
  logic w_err;
  // in_parity is the even-parity bit, so it must equal the XOR of the code bits.
  assign w_err          = (^bus.in_code) != bus.in_parity;
  assign w_pay          = {w_err, (w_err ? {c_N_OUT{1'b0}} : w_word)};
  assign bus.out_err    = w_head[c_N_OUT];
`else
  assign w_pay          = w_word;
`endif

  skid_buf2 #(
    .W (c_PAY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.in_valid),
    .o_ready (w_in_ready),
    .i_data  (w_pay),
    .o_valid (w_out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_head)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_onehot = w_head[c_N_OUT-1:0];
  assign bus.count      = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_out_valid && bus.out_ready) begin
      r_count <= r_count + {{N_IN{1'b0}}, 1'b1};
    end
  end

endmodule

`default_nettype wire
